// File: rtl/srtc_responder.sv
// S-RTC responder for SNES registers $2800 (read) and $2801 (write): nibble protocol FSM.
// Define SRTC_WRITE_EN to build the WRITE state and the shadow/commit path toward the MCU.
module srtc_responder (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        srtc_enable,
  input  logic        SNES_ADDR0,
  input  logic        reg_oe_strobe,
  input  logic        reg_we_strobe,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic [51:0] rtc_data_in,
  output logic [51:0] rtc_data_out,
  output logic        rtc_we,
  output logic [1:0]  srtc_mode
);

  typedef enum logic [1:0] {
    StReady   = 2'd0,
    StCommand = 2'd1,
    StRead    = 2'd2,
    StWrite   = 2'd3
  } mode_e;

  localparam logic [3:0] IdxPre   = 4'hF;
  localparam logic [3:0] IdxLast  = 4'd13;
  localparam logic [3:0] CmdRead  = 4'hD;
  localparam logic [3:0] CmdEnter = 4'hE;
  localparam logic [3:0] CmdNop   = 4'hF;

  mode_e            mode_q;
  logic [3:0]       index_q;
  logic [12:0][3:0] snap_q;

  logic       wr_hit;
  logic       rd_hit;
  logic [3:0] wr_data;
  logic       unused_di;

  // A simultaneous write wins; the read is dropped and DO holds.
  assign wr_hit    = srtc_enable & reg_we_strobe;
  assign rd_hit    = srtc_enable & reg_oe_strobe & ~wr_hit;
  assign wr_data   = DI[3:0];
  assign unused_di = ^DI[7:4];
  assign srtc_mode = mode_q;

`ifdef SRTC_WRITE_EN
  logic [12:0][3:0] shadow_q;
  logic [12:0][3:0] shadow_next;

  // Shadow with the incoming digit merged, so the 13th digit commits in the same edge.
  always_comb begin
    shadow_next = shadow_q;
    if (index_q < IdxLast) begin
      shadow_next[index_q] = wr_data;
    end
  end
`else
  assign rtc_data_out = '0;
  assign rtc_we       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q       <= StReady;
      index_q      <= IdxPre;
      snap_q       <= '0;
      DO           <= 8'h00;
`ifdef SRTC_WRITE_EN
      shadow_q     <= '0;
      rtc_data_out <= '0;
      rtc_we       <= 1'b0;
`endif
    end else begin
`ifdef SRTC_WRITE_EN
      rtc_we <= 1'b0;
`endif
      if (wr_hit) begin
        if (SNES_ADDR0) begin
          if (wr_data == CmdRead) begin
            mode_q  <= StRead;
            index_q <= IdxPre;
            snap_q  <= rtc_data_in;
          end else if (wr_data == CmdEnter) begin
            mode_q <= StCommand;
          end else if (wr_data != CmdNop) begin
            unique case (mode_q)
              StCommand: begin
`ifdef SRTC_WRITE_EN
                if (wr_data == 4'd0) begin
                  mode_q  <= StWrite;
                  index_q <= 4'd0;
                end else if (wr_data == 4'd4) begin
                  shadow_q     <= '0;
                  rtc_data_out <= '0;
                  rtc_we       <= 1'b1;
                  mode_q       <= StReady;
                end else begin
                  mode_q <= StReady;
                end
`else
                mode_q <= StReady;
`endif
              end
`ifdef SRTC_WRITE_EN
              StWrite: begin
                if (index_q < IdxLast) begin
                  shadow_q <= shadow_next;
                  index_q  <= index_q + 4'd1;
                  if (index_q == IdxLast - 4'd1) begin
                    rtc_data_out <= shadow_next;
                    rtc_we       <= 1'b1;
                    mode_q       <= StReady;
                  end
                end
              end
`endif
              default: begin
              end
            endcase
          end
        end
      end else if (rd_hit) begin
        if (!SNES_ADDR0 && mode_q == StRead) begin
          if (index_q == IdxPre) begin
            DO      <= 8'h0F;
            index_q <= 4'd0;
          end else if (index_q < IdxLast) begin
            DO      <= {4'h0, snap_q[index_q]};
            index_q <= index_q + 4'd1;
          end else begin
            // End marker: wrap and relatch so the next pass sees fresh time.
            DO      <= 8'h0F;
            index_q <= IdxPre;
            snap_q  <= rtc_data_in;
          end
        end else begin
          DO <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_srtc_responder.sv
// Bench for srtc_responder: spec vector table, hand-written corner sequences, and
// randomized accesses against a queue-based reference model. Honours SRTC_WRITE_EN.
module tb_srtc_responder;

`ifdef SRTC_WRITE_EN
  localparam bit WrEn = 1'b1;
`else
  localparam bit WrEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        srtc_enable = 1'b0;
  logic        SNES_ADDR0 = 1'b0;
  logic        reg_oe_strobe = 1'b0;
  logic        reg_we_strobe = 1'b0;
  logic [7:0]  DI = 8'h00;
  logic [7:0]  DO;
  logic [51:0] rtc_data_in = '0;
  logic [51:0] rtc_data_out;
  logic        rtc_we;
  logic [1:0]  srtc_mode;

  int n_tests = 0;
  int n_fail  = 0;

  srtc_responder dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .srtc_enable  (srtc_enable),
    .SNES_ADDR0   (SNES_ADDR0),
    .reg_oe_strobe(reg_oe_strobe),
    .reg_we_strobe(reg_we_strobe),
    .DI           (DI),
    .DO           (DO),
    .rtc_data_in  (rtc_data_in),
    .rtc_data_out (rtc_data_out),
    .rtc_we       (rtc_we),
    .srtc_mode    (srtc_mode)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending reply bytes and collected write digits as queues.
  int          m_mode;
  logic [7:0]  m_do;
  logic [51:0] m_out;
  bit          m_we;
  logic [7:0]  rq[$];
  logic [3:0]  wq[$];

  function automatic void refill();
    rq.delete();
    rq.push_back(8'h0F);
    for (int i = 0; i < 13; i++) rq.push_back({4'h0, rtc_data_in[4*i +: 4]});
    rq.push_back(8'h0F);
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_do   = 8'h00;
    m_out  = '0;
    m_we   = 1'b0;
    rq.delete();
    wq.delete();
  endfunction

  function automatic void model_step(bit we, bit oe, bit a0, bit en, logic [3:0] d);
    m_we = 1'b0;
    if (en && we) begin
      if (a0) begin
        if (d == 4'hD) begin
          m_mode = 2;
          refill();
        end else if (d == 4'hE) begin
          m_mode = 1;
        end else if (d != 4'hF) begin
          if (m_mode == 1) begin
            if (WrEn && d == 4'd0) begin
              m_mode = 3;
              wq.delete();
            end else if (WrEn && d == 4'd4) begin
              m_out  = '0;
              m_we   = 1'b1;
              m_mode = 0;
            end else begin
              m_mode = 0;
            end
          end else if (m_mode == 3) begin
            wq.push_back(d);
            if (wq.size() == 13) begin
              for (int i = 0; i < 13; i++) m_out[4*i +: 4] = wq[i];
              m_we   = 1'b1;
              m_mode = 0;
            end
          end
        end
      end
    end else if (en && oe) begin
      if (!a0 && m_mode == 2) begin
        m_do = rq.pop_front();
        if (rq.size() == 0) refill();
      end else begin
        m_do = 8'h00;
      end
    end
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(string nm);
    chk({nm, "_do"}, 64'(DO), 64'(m_do));
    chk({nm, "_mode"}, 64'(srtc_mode), 64'(m_mode));
    chk({nm, "_we"}, 64'(rtc_we), 64'(m_we));
    chk({nm, "_out"}, 64'(rtc_data_out), 64'(m_out));
  endtask

  task automatic access(bit we, bit oe, bit a0, bit en, logic [3:0] d, string nm);
    logic [3:0] hi;
    hi = 4'($urandom);
    @(negedge CLK);
    reg_we_strobe = we;
    reg_oe_strobe = oe;
    SNES_ADDR0    = a0;
    srtc_enable   = en;
    DI            = {hi, d};
    @(posedge CLK);
    #1;
    model_step(we, oe, a0, en, d);
    reg_we_strobe = 1'b0;
    reg_oe_strobe = 1'b0;
    check_all(nm);
  endtask

  task automatic do_reset(string nm);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all(nm);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  typedef struct {
    bit         we;
    bit         oe;
    bit         a0;
    logic [3:0] d;
    logic [7:0] exp_do;
    logic [1:0] exp_mode;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] dig[13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                          4'd1, 4'd2, 4'd3, 4'd4};
  logic [7:0] rd_exp[17] = '{8'h0F, 8'h05, 8'h04, 8'h00, 8'h03, 8'h09, 8'h00, 8'h05,
                             8'h01, 8'h07, 8'h04, 8'h02, 8'h01, 8'h02, 8'h0F, 8'h0F,
                             8'h05};

  initial begin
    int         we_cnt;
    int         kind;
    int         r;
    bit         s_we;
    bit         s_oe;
    bit         s_a0;
    bit         s_en;
    logic [3:0] s_d;

    model_reset();
    do_reset("reset");

    // Spec vectors: idle read, READ entry, full sequence plus wrap.
    rtc_data_in = 52'h2124715093045;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 4'hD, 8'h00, 2'd2});
    for (int i = 0; i < 17; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, rd_exp[i], 2'd2});
    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].we, tbl[i].oe, tbl[i].a0, 1'b1, tbl[i].d, "tbl");
      chk($sformatf("tbl%0d_do", i), 64'(DO), 64'(tbl[i].exp_do));
      chk($sformatf("tbl%0d_mode", i), 64'(srtc_mode), 64'(tbl[i].exp_mode));
    end

    // Full 13-digit write: one rtc_we pulse on the 13th digit.
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'hE, "cmd");
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, "wr0");
    chk("mode_after_0", 64'(srtc_mode), WrEn ? 64'd3 : 64'd0);
    we_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      access(1'b1, 1'b0, 1'b1, 1'b1, dig[i], "dig");
      if (rtc_we) we_cnt++;
      if (i == 12) chk("we_on_13th", 64'(rtc_we), 64'(WrEn));
    end
    access(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "idle");
    if (rtc_we) we_cnt++;
    chk("write_we_count", 64'(we_cnt), WrEn ? 64'd1 : 64'd0);
    chk("write_data", 64'(rtc_data_out), WrEn ? 64'h4321987654321 : 64'd0);
    chk("write_mode", 64'(srtc_mode), 64'd0);

    // Clear command.
    we_cnt = 0;
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'hE, "cmd");
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'h4, "clr");
    if (rtc_we) we_cnt++;
    access(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "idle");
    if (rtc_we) we_cnt++;
    chk("clear_we_count", 64'(we_cnt), WrEn ? 64'd1 : 64'd0);
    chk("clear_data", 64'(rtc_data_out), 64'd0);
    chk("clear_mode", 64'(srtc_mode), 64'd0);

    // Write wins over a simultaneous read; unqualified strobes are ignored.
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'hD, "rd_entry");
    access(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, "rd_pre");
    access(1'b1, 1'b1, 1'b1, 1'b1, 4'hD, "both");
    chk("both_mode", 64'(srtc_mode), 64'd2);
    chk("both_do", 64'(DO), 64'h0F);
    access(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, "rd_pre2");
    access(1'b1, 1'b0, 1'b1, 1'b0, 4'hE, "we_noen");
    chk("noen_we_mode", 64'(srtc_mode), 64'd2);
    access(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, "oe_noen");
    access(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, "rd_n0");
    chk("noen_oe_do", 64'(DO), 64'h05);

    // Reset in the middle of a write discards partial digits.
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'hE, "cmd");
    access(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, "wr0");
    for (int i = 0; i < 5; i++) access(1'b1, 1'b0, 1'b1, 1'b1, dig[i], "pre_rst");
    do_reset("mid_reset");
    for (int i = 5; i < 13; i++) access(1'b1, 1'b0, 1'b1, 1'b1, dig[i], "post_rst");
    chk("post_rst_out", 64'(rtc_data_out), 64'd0);

    // Randomized accesses against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) rtc_data_in = {20'($urandom), 32'($urandom)};
      if (n % 700 == 699) do_reset("rand_reset");
      kind = $urandom_range(0, 9);
      r    = $urandom_range(0, 9);
      s_we = (kind < 4);
      s_oe = (kind >= 3) && (kind < 9);
      s_a0 = s_we ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      s_en = ($urandom_range(0, 15) != 0);
      if (m_mode == 3 && r < 9) s_d = 4'($urandom_range(0, 12));
      else if (r < 2) s_d = 4'hD;
      else if (r < 4) s_d = 4'hE;
      else if (r < 5) s_d = 4'h0;
      else if (r < 6) s_d = 4'h4;
      else s_d = 4'($urandom);
      if (m_mode == 3 && s_en) begin
        s_we = 1'b1;
        s_a0 = 1'b1;
      end
      access(s_we, s_oe, s_a0, s_en, s_d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
